dir_cmd_queue: RTL

// - Sits between keypad_scanner and ghost. Turns the raw 3-bit direction code into clean, one-shot move commands.
// - Synchronises the code into the ghost clock domain, debounces it and generates edge and auto-repeat events.
// - Queues the events in a small FWFT FIFO. ghost pops one command per move, so no press is lost between ghost steps.

---
 rtl/dir_cmd_queue_pkg.sv | 22 ++
 rtl/dir_fifo.sv | 72 +++++++
 rtl/dir_cmd_queue.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dir_cmd_queue_pkg.sv
// Direction codes and repeat-FSM encoding.
// keypad_scanner, dir_cmd_queue and ghost all use these definitions.
package dir_cmd_queue_pkg;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_t;

    // Codes above DIR_RIGHT are not real keys; treat them as "no key".
    function automatic logic [2:0] dir_sanitize(input logic [2:0] raw);
        return (raw > DIR_RIGHT) ? DIR_NONE : raw;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small first-word-fall-through queue of direction codes.
// The head entry is presented on dout while the queue is non-empty.
module dir_fifo
    import dir_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [2:0]    din,
    input  logic          pop,
    input  logic          clear,
    output logic [2:0]    dout,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          overflow
);

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, do_pop, do_push;

    // Pointer/count bookkeeping; a pop on a full queue frees the slot for a same-cycle push.
    always_comb begin
        full     = (cnt_q == (AW+1)'(DEPTH));
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
            ovf_d = push && !do_push;
        end
    end

    // State registers and storage; storage is cleared too so dout never shows stale codes after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DIR_NONE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            if (!clear && do_push) mem_q[wr_ptr_q] <= din;
        end
    end

    assign valid    = (cnt_q != '0);
    assign dout     = valid ? mem_q[rd_ptr_q] : DIR_NONE;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/dir_cmd_queue.sv
// Keypad direction conditioner: synchronise, debounce, make press and
// auto-repeat events, and queue them for ghost.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no key accepted (or hold after clear); no repeats
//  ST_WAIT | key just pushed; counting down the initial repeat delay
//  ST_RPT  | auto-repeating; push every repeat period
module dir_cmd_queue
    import dir_cmd_queue_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = 2000,
    parameter int REPEAT_DELAY  = 40000,
    parameter int REPEAT_PERIOD = 15000,
    parameter int DEPTH         = 4,
    parameter int CNT_W         = 16
) (
    input  logic                     clock_100KHz,
    input  logic                     rst,
    input  logic [2:0]               directions,
    input  logic                     clear,
    input  logic                     pop,
    output logic [2:0]               dir_out,
    output logic                     dir_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'(REPEAT_PERIOD - 1);

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       code_n, code_s;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]       acc_q, acc_d;
    logic             stable, accept;
    rpt_state_t       state_q, state_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             hold_q, hold_d;
    logic             push_req;
    logic [2:0]       push_code;

    // Debounce: the change is seen one stage early (sync1 vs sync2) so the
    // raw-to-accept latency is DEBOUNCE_CYC+2 edges.
    always_comb begin
        code_n   = dir_sanitize(sync1_q);
        code_s   = dir_sanitize(sync2_q);
        stable   = (code_n == code_s);
        accept   = stable && (db_cnt_q == DB_LAST) && (code_s != acc_q);
        db_cnt_d = db_cnt_q;
        if (!stable)                db_cnt_d = '0;
        else if (db_cnt_q != DB_LAST) db_cnt_d = db_cnt_q + 1'b1;
        acc_d    = accept ? code_s : acc_q;
        hold_d   = clear ? 1'b1 : ((acc_d == DIR_NONE) ? 1'b0 : hold_q);
    end

    // Repeat FSM next state and push generation; a code change always wins over a repeat tick.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        push_req  = 1'b0;
        push_code = acc_q;
        if (clear || hold_q) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
        end else if (accept) begin
            if (code_s != DIR_NONE) begin
                push_req  = 1'b1;
                push_code = code_s;
                state_d   = ST_WAIT;
                rpt_cnt_d = RD_LOAD;
            end else begin
                state_d   = ST_IDLE;
                rpt_cnt_d = '0;
            end
        end else begin
            case (state_q)
                ST_WAIT, ST_RPT: begin
                    if (rpt_cnt_q == '0) begin
                        push_req  = 1'b1;
                        state_d   = ST_RPT;
                        rpt_cnt_d = RP_LOAD;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchroniser, debounce, accepted code, hold flag and repeat FSM registers.
    always_ff @(posedge clock_100KHz or posedge rst) begin
        if (rst) begin
            sync1_q   <= DIR_NONE;
            sync2_q   <= DIR_NONE;
            db_cnt_q  <= '0;
            acc_q     <= DIR_NONE;
            hold_q    <= 1'b0;
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= directions;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            acc_q     <= acc_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clock_100KHz),
        .rst      (rst),
        .push     (push_req),
        .din      (push_code),
        .pop      (pop),
        .clear    (clear),
        .dout     (dir_out),
        .valid    (dir_valid),
        .count    (count),
        .overflow (overflow)
    );

endmodule
